// File: rtl/kronos_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// kronos_fetch_queue_if : IF->ID fetch-queue handshake bundle  | Rev 1.0
// ============================================================================
interface kronos_fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  logic [31:0]              in_pc;
  logic [31:0]              in_ir;
  logic                     in_vld;
  logic                     in_rdy;
  logic [31:0]              out_pc;
  logic [31:0]              out_ir;
  logic                     out_vld;
  logic                     out_rdy;
  logic                     flush;
  logic [$clog2(DEPTH):0]   level;

  // master = fetch/decode side driving the queue; slave = the queue itself
  modport master (
    output in_pc, in_ir, in_vld, out_rdy, flush,
    input  in_rdy, out_pc, out_ir, out_vld, level
  );

  modport slave (
    input  in_pc, in_ir, in_vld, out_rdy, flush,
    output in_rdy, out_pc, out_ir, out_vld, level
  );
endinterface
`default_nettype wire

// File: rtl/kronos_fetch_queue.sv
`default_nettype none
// ============================================================================
// kronos_fetch_queue : {pc, ir} FIFO between fetch and decode, flushable
// Rev 1.0
// ============================================================================
module kronos_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstz,
  kronos_fetch_queue_if.slave   bus
);
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_PW = c_AW + 1;

  logic [63:0]      r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [63:0]      w_head;

  // Extra wrap bit on each pointer distinguishes full from empty
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // in_rdy depends only on state, flush and reset, never on out_rdy
  assign bus.in_rdy  = rstz & ~w_full & ~bus.flush;
  assign bus.out_vld = ~w_empty & ~bus.flush;

  assign w_push = bus.in_vld & bus.in_rdy;
  assign w_pop  = bus.out_vld & bus.out_rdy;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {bus.in_pc, bus.in_ir};
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];
  assign bus.out_pc = w_empty ? 32'd0 : w_head[63:32];
  assign bus.out_ir = w_empty ? 32'd0 : w_head[31:0];
  assign bus.level  = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire
